// File: rtl/muldiv_ctrl.sv
//==============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the Execute stage
//               (fixed-latency multiplier, radix-2 restoring divider).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ismult,
  input  logic        signedmult,
  input  logic        isdiv,
  input  logic        signeddiv,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] c_MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] c_DIV_LAST = 6'd31;

  state_t      r_state, w_next;
  logic        r_signed, r_dz, r_neg_q, r_neg_r;
  logic [5:0]  r_cnt;
  logic [31:0] r_a, r_b, r_quo, r_rem;

  logic        w_start_mul, w_start_div, w_mul_end, w_div_end;
  logic [31:0] w_a_mag, w_b_mag;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic [32:0] w_shift, w_diff;
  logic [31:0] w_rem_nx, w_quo_nx, w_q_fin, w_r_fin;

  assign w_start_mul = (r_state == S_IDLE) & ismult & ~flush;
  assign w_start_div = (r_state == S_IDLE) & ~ismult & isdiv & ~flush;
  assign w_mul_end   = (r_state == S_MUL) && (r_cnt == c_MUL_LAST);
  assign w_div_end   = (r_state == S_DIV) && (r_dz || (r_cnt == c_DIV_LAST));

  assign w_a_mag = (signeddiv & a[31]) ? (~a + 32'd1) : a;
  assign w_b_mag = (signeddiv & b[31]) ? (~b + 32'd1) : b;

  // Sign-extending to 64 bits lets one truncated multiplier serve both forms
  assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
  assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Bit 32 of the difference is the borrow: set when the divisor does not fit
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_rem_nx = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
  assign w_quo_nx = {r_quo[30:0], ~w_diff[32]};
  assign w_q_fin  = r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
  assign w_r_fin  = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_start_mul | w_start_div;
        if (w_start_mul)      w_next = S_MUL;
        else if (w_start_div) w_next = S_DIV;
      end
      S_MUL: begin
        stall_o = 1'b1;
        if (w_mul_end) w_next = S_DONE;
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (w_div_end) w_next = S_DONE;
      end
      S_DONE: begin
        valid_o = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_signed <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= 6'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      hi_o     <= 32'd0;
      lo_o     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mul) begin
            r_cnt    <= 6'd0;
            r_a      <= a;
            r_b      <= b;
            r_signed <= signedmult;
          end else if (w_start_div) begin
            r_cnt    <= 6'd0;
            r_a      <= a;
            r_b      <= w_b_mag;
            r_quo    <= w_a_mag;
            r_rem    <= 32'd0;
            r_dz     <= (b == 32'd0);
            r_neg_q  <= signeddiv & (a[31] ^ b[31]);
            r_neg_r  <= signeddiv & a[31];
          end
        end
        S_MUL: begin
          if (!flush) begin
            r_cnt <= r_cnt + 6'd1;
            if (w_mul_end) begin
              hi_o <= w_prod[63:32];
              lo_o <= w_prod[31:0];
            end
          end
        end
        S_DIV: begin
          if (!flush) begin
            r_cnt <= r_cnt + 6'd1;
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (w_div_end) begin
              if (r_dz) begin
                hi_o <= r_a;
                lo_o <= 32'hFFFF_FFFF;
              end else begin
                hi_o <= w_r_fin;
                lo_o <= w_q_fin;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
//==============================================================================
// Module      : tb_muldiv_ctrl
// Description : Scoreboard bench for muldiv_ctrl (results, latency, flush, reset).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_muldiv_ctrl;

  localparam int MUL_CYCLES = 2;
  localparam int c_MUL_LAT  = MUL_CYCLES + 1;
  localparam int c_DIV_LAT  = 33;
  localparam int c_DZ_LAT   = 2;

  logic        clk = 1'b0;
  logic        rst, ismult, signedmult, isdiv, signeddiv, flush;
  logic [31:0] a, b;
  logic        stall_o, valid_o;
  logic [31:0] hi_o, lo_o;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ismult     (ismult),
    .signedmult (signedmult),
    .isdiv      (isdiv),
    .signeddiv  (signeddiv),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {hi, lo} for one operation
  function automatic logic [63:0] model(input bit mul, input bit sgn,
                                        input logic [31:0] opa, input logic [31:0] opb);
    logic signed [63:0] sa, sb;
    int ia, ib, q, r;
    if (mul) begin
      if (sgn) begin
        sa = $signed({{32{opa[31]}}, opa});
        sb = $signed({{32{opb[31]}}, opb});
        return 64'(sa * sb);
      end
      return {32'd0, opa} * {32'd0, opb};
    end
    if (opb == 32'd0) return {opa, 32'hFFFF_FFFF};
    if (sgn && opa == 32'h8000_0000 && opb == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (sgn) begin
      ia = opa;
      ib = opb;
      q  = ia / ib;
      r  = ia % ib;
      return {32'(r), 32'(q)};
    end
    return {opa % opb, opa / opb};
  endfunction

  // Holds the request for the whole operation (including DONE) and scrambles
  // operands while stalled; neither may affect the result.
  task automatic run_op(input string tag, input bit mul, input bit sgn,
                        input logic [31:0] opa, input logic [31:0] opb, input int lat);
    int cyc, stalls;
    logic [63:0] exp;
    sb_q.push_back(model(mul, sgn, opa, opb));
    @(posedge clk); #1;
    ismult = mul; isdiv = ~mul; signedmult = sgn; signeddiv = sgn; a = opa; b = opb;
    #1;
    cyc = 0;
    stalls = 0;
    while (!valid_o && cyc < 100) begin
      if (stall_o) stalls++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
      #1;
      cyc++;
    end
    exp = sb_q.pop_front();
    if (!valid_o) begin
      check({tag, "_timeout"}, 64'(valid_o), 64'd1);
    end else begin
      check({tag, "_lat"}, 64'(cyc), 64'(lat));
      check({tag, "_stall"}, 64'(stalls), 64'(lat));
      check({tag, "_donestall"}, 64'(stall_o), 64'd0);
      check({tag, "_res"}, {hi_o, lo_o}, exp);
    end
    @(posedge clk); #1;
    ismult = 1'b0; isdiv = 1'b0;
    #1;
    check({tag, "_after"}, 64'({valid_o, stall_o}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prev;
    logic [31:0] ra, rb;
    bit          rm, rs;
    int          nvalid;

    rst = 1'b1; ismult = 1'b0; signedmult = 1'b0; isdiv = 1'b0; signeddiv = 1'b0;
    flush = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_flags", 64'({valid_o, stall_o}), 64'd0);
    rst = 1'b0;

    run_op("multu",    1, 0, 32'hFFFF_FFFF, 32'd2,         c_MUL_LAT);
    run_op("mult",     1, 1, 32'hFFFF_FFFF, 32'd2,         c_MUL_LAT);
    run_op("divu",     0, 0, 32'd100,       32'd7,         c_DIV_LAT);
    run_op("div_neg",  0, 1, 32'hFFFF_FFF9, 32'd2,         c_DIV_LAT);
    run_op("div_ovf",  0, 1, 32'h8000_0000, 32'hFFFF_FFFF, c_DIV_LAT);
    run_op("div_zero", 0, 1, 32'h0000_1234, 32'd0,         c_DZ_LAT);
    run_op("divu_big", 0, 0, 32'hFFFF_FFFF, 32'h8000_0001, c_DIV_LAT);
    run_op("div_mix",  0, 1, 32'd1000,      32'hFFFF_FFF9, c_DIV_LAT);

    for (int i = 0; i < 6; i++) begin
      rm = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i == 2) rb = rb >> 24;
      run_op("rand", rm, rs, ra, rb, rm ? c_MUL_LAT : (rb == 32'd0 ? c_DZ_LAT : c_DIV_LAT));
    end

    // Flush mid-divide: abort, no valid, HI/LO untouched
    prev = {hi_o, lo_o};
    @(posedge clk); #1;
    isdiv = 1'b1; signeddiv = 1'b0; a = 32'd100; b = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    check("flush_stall10", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; isdiv = 1'b0;
    #1;
    check("flush_stall11", 64'(stall_o), 64'd0);
    nvalid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) nvalid++;
    end
    check("flush_novalid", 64'(nvalid), 64'd0);
    check("flush_hilo", {hi_o, lo_o}, prev);

    // Flush coinciding with a request in IDLE: never started
    @(posedge clk); #1;
    ismult = 1'b1; signedmult = 1'b0; flush = 1'b1; a = 32'd3; b = 32'd5;
    #1;
    check("flush_idle_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    ismult = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle_next", 64'({valid_o, stall_o}), 64'd0);

    // Asynchronous reset mid-divide
    run_op("pre_rst", 1, 0, 32'h0001_0001, 32'h0003_0003, c_MUL_LAT);
    @(posedge clk); #1;
    isdiv = 1'b1; signeddiv = 1'b0; a = 32'd100; b = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1; isdiv = 1'b0;
    #1;
    check("arst_hilo", {hi_o, lo_o}, 64'd0);
    check("arst_flags", 64'({valid_o, stall_o}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post_rst", 0, 0, 32'd100, 32'd7, c_DIV_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the Execute stage. Accepts MULT/MULTU/DIV/DIVU requests from the decoded control signals (`ismult`, `signedmult`, `isdiv`, `signeddiv`) and runs an iterative radix-2 divider or a fixed-latency multiplier. It holds the pipeline with `stall_o` until the 64-bit result is ready, then presents HI/LO with a one-cycle valid pulse for the HI/LO register write (`hiwrite`/`lowrite` path).

## Interface
- MUL_CYCLES, 2, cycles spent in MUL state (≥1); product registered at end
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ismult  in  1  multiply request (E stage)
- signedmult  in  1  1 = MULT, 0 = MULTU
- isdiv  in  1  divide request (E stage)
- signeddiv  in  1  1 = DIV, 0 = DIVU
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- flush  in  1  exception/ERET flush; aborts any operation
- stall_o  out  1  hold F/D/E stages
- valid_o  out  1  one-cycle pulse: hi_o/lo_o are new
- hi_o  out  32  HI result (product[63:32] / remainder)
- lo_o  out  32  LO result (product[31:0] / quotient)

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - `ismult & ~flush` → MUL.
  - Else `isdiv & ~flush` → DIV. Mult has priority if both are set.
  - Operands and sign flags are latched on the start edge.
- Inputs are ignored outside IDLE.
- MUL:
  - Counter runs MUL_CYCLES cycles, then → DONE.
  - Product is the full 64-bit signed or unsigned product of the latched operands.
- DIV:
  - Divide by zero (b == 0) → DONE after 1 cycle with hi = a, lo = 32'hFFFFFFFF.
  - Otherwise 32 restoring shift-subtract iterations on operand magnitudes (unsigned: operands as-is), then → DONE.
  - Signed fix-up: quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed: lo = 0x80000000, hi = 0.
- DONE:
  - hi_o/lo_o were loaded on the entry edge; valid_o = 1, stall_o = 0.
  - → IDLE unconditionally. The request still present in E this cycle does not restart.
- flush:
  - Any state → IDLE on the next edge.
  - No valid_o; hi_o/lo_o keep their prior values.
- hi_o/lo_o change only on entry to DONE.

## Timing
- Reset values: state IDLE; hi_o = lo_o = 0; valid_o = 0; stall_o = 0; counters 0.
- stall_o (combinational):
  - 1 in IDLE when a request is accepted (`(ismult|isdiv) & ~flush`).
  - 1 throughout MUL and DIV.
  - 0 in DONE and otherwise.
- Cycle 0 = IDLE cycle with the request.
  - Mult: stall cycles 0..MUL_CYCLES; DONE (valid) at cycle MUL_CYCLES+1.
  - Div: stall cycles 0..32; DONE at cycle 33.
  - Div by zero: DONE at cycle 2.
- Back-to-back requests: a new request is accepted in the IDLE cycle right after DONE. Minimum spacing = latency + 1.
- flush with a request in IDLE: not started; stall_o = 0.
- Reset mid-operation: immediate return to reset values (asynchronous).

## Test plan
- MULTU a=0xFFFFFFFF, b=2 (MUL_CYCLES=2) → stall 3 cycles; valid at cycle 3; hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=0xFFFFFFFF, b=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE; single valid pulse.
- DIVU a=100, b=7 → stall cycles 0..32; valid at cycle 33; lo=14, hi=2.
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV b=0, a=0x1234 → valid at cycle 2; hi=0x1234, lo=0xFFFFFFFF.
- DIVU started, then flush at cycle 10 → IDLE at cycle 11, stall drops, no valid, hi/lo unchanged. Repeat with rst asserted mid-DIV → all outputs 0 immediately.
